bcd_serial_adder: RTL and testbench
===================================

Name: bcd_serial_adder

Overview:
- Parametrised multi-digit packed-BCD adder that processes one decimal digit per clock, least significant digit first.
- Successor to the single-digit combinational BCD adder. Adds N-digit width, a start/busy/done handshake, and an invalid-digit flag.
- Sits between operand registers and the 7-segment/display datapath. Accepts a new operation only when idle.

Parameters:
- NDIGITS, 4, number of BCD digits per operand (legal range 2..16).
- CNT_W, $clog2(NDIGITS), width of the digit counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  4*NDIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  in  4*NDIGITS  operand B, packed BCD.
- cin  in  1  carry into digit 0.
- sub  in  1  subtract mode. Honoured only when BCD_SUB_EN is defined.
- sum  out  4*NDIGITS  result, packed BCD.
- cout  out  1  decimal carry out of the top digit.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- err  out  1  at least one input digit of a or b was greater than 9.

Behaviour:
- Reset: one clock is used; reset is synchronous and active-high. On rst=1 at a clock edge:
  - state <= IDLE.
  - sum, cout, busy, done, err and the digit counter <= 0.
  - Reset mid-RUN aborts the operation with no done pulse.
- States:
  - IDLE -> RUN when start=1.
  - RUN -> DONE after the digit counter reaches NDIGITS-1.
  - DONE -> IDLE unconditionally.
- Capture: on the edge that accepts start, a, b, cin and sub are copied into internal shift registers.
  - The carry register is loaded with cin (add) or 1 (sub).
  - sum is cleared.
  - err is set to the OR of per-digit (digit > 9) checks over a and b.
- RUN, per cycle for digit i:
  - s = A_i + B'_i + c, 5-bit binary.
  - If s > 9: digit = (s + 6) mod 16 and c_next = 1; otherwise digit = s and c_next = 0.
  - The digit is shifted into sum from the top, so sum is fully aligned after the last digit.
  - Operand registers shift right by 4; counter increments.
- Latency: start accepted at edge k; digits processed at edges k+1..k+NDIGITS.
  - done=1 and busy=0 in the cycle following edge k+NDIGITS.
  - Total NDIGITS+1 cycles from start to done.
- busy is high exactly NDIGITS cycles.
- start while busy or in DONE is ignored: no re-capture and no queueing.
- sum, cout and err hold their values until the next accepted start or reset.
- Invalid digits: the computation proceeds using the same correction rule and err stays set. Result content is unspecified except that it is deterministic.
- Wrap-around: overflow beyond NDIGITS digits is reported only via cout; sum wraps mod 10^NDIGITS.

Optional Feature:
- Macro: BCD_SUB_EN.
- Defined:
  - sub=1 computes A - B via ten's complement: B'_i = 9 - B_i and initial carry = 1 (cin ignored).
  - cout=1 means A >= B and sum = A - B.
  - cout=0 means A < B and sum = 10^NDIGITS - (B - A).
  - err checks are applied before complementing.
- Undefined: sub is ignored, B'_i = B_i, and the complement logic is not synthesised.

Decomposition:
- Shared package bcd_pkg:
  - constant DIGIT_W = 4.
  - typedef bcd_digit_t (logic [3:0]).
  - enum state_t {IDLE, RUN, DONE}.
  - function is_bcd(digit) returning 1 when the digit is 9 or less.
  - function nines(digit) returning 9 - digit.
- One sub-module, bcd_digit_adder (combinational).
  - Inputs: two digits and a carry-in.
  - Outputs: corrected digit and carry out.
  - Instantiated once and reused each cycle.

Test Plan:
- N=4, a=1234, b=5678, cin=0, start pulse -> done pulse on cycle 5 after start, sum=6912, cout=0, err=0, busy high for 4 cycles.
- a=9999, b=0001, cin=0 -> sum=0000, cout=1. Repeat with a=0000, b=0000, cin=1 -> sum=0001, cout=0.
- a=00A0, b=0000 -> err=1 with done still pulsed at cycle 5. Then a valid start -> err returns to 0.
- start re-asserted on cycle 2 with a=1111, b=1111 during the 1234+5678 op -> ignored, result still 6912, single done pulse.
- rst=1 on cycle 3 of an operation -> next cycle all outputs 0, state IDLE, no done. A following start completes normally.
- BCD_SUB_EN defined, sub=1:
  - 0500 - 0123 -> sum=0377, cout=1.
  - 0123 - 0500 -> sum=9623, cout=0.
  - Same vectors with the macro undefined -> addition results 0623 / 0623.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the serial BCD adder.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

  // Nine's complement; wraps for non-BCD inputs, which keeps results deterministic.
  function automatic bcd_digit_t nines(input bcd_digit_t d);
    return 4'(4'd9 - d);
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal (+6) correction.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t i_a,
  input  bcd_digit_t i_b,
  input  logic       i_c,
  output bcd_digit_t o_digit_c,
  output logic       o_carry_c
);

  logic [4:0] w_s;

  always_comb begin
    w_s       = 5'(i_a) + 5'(i_b) + 5'(i_c);
    o_digit_c = w_s[3:0];
    o_carry_c = 1'b0;
    if (w_s > 5'd9) begin
      o_digit_c = 4'(w_s + 5'd6);
      o_carry_c = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, LSD first.
// Define BCD_SUB_EN to enable ten's-complement subtraction via the sub input.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter  int unsigned NDIGITS = 4,
  localparam int unsigned CNT_W   = $clog2(NDIGITS),
  localparam int unsigned W       = DIGIT_W * NDIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_in_err;
  logic             w_carry_init;
  bcd_digit_t       w_b_digit;
  bcd_digit_t       w_digit;
  logic             w_carry;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_cnt == CNT_W'(NDIGITS - 1));

`ifdef BCD_SUB_EN
  logic r_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= sub;
    end
  end

  assign w_b_digit    = r_sub ? nines(r_b[DIGIT_W-1:0]) : r_b[DIGIT_W-1:0];
  assign w_carry_init = sub ? 1'b1 : cin;
`else
  logic w_unused_sub;

  assign w_unused_sub = sub;
  assign w_b_digit    = r_b[DIGIT_W-1:0];
  assign w_carry_init = cin;
`endif

  // Invalid-digit screen on the raw operands, before any complementing.
  always_comb begin
    w_in_err = 1'b0;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (!is_bcd(a[i*DIGIT_W +: DIGIT_W]) || !is_bcd(b[i*DIGIT_W +: DIGIT_W])) begin
        w_in_err = 1'b1;
      end
    end
  end

  bcd_digit_adder u_digit (
    .i_a       (r_a[DIGIT_W-1:0]),
    .i_b       (w_b_digit),
    .i_c       (r_carry),
    .o_digit_c (w_digit),
    .o_carry_c (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, then shift one digit per RUN cycle into sum from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_busy <= (w_next == RUN);
      r_done <= (w_next == DONE);
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= w_carry_init;
        r_sum   <= '0;
        r_cout  <= 1'b0;
        r_err   <= w_in_err;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_sum   <= {w_digit, r_sum[W-1:DIGIT_W]};
        r_a     <= r_a >> DIGIT_W;
        r_b     <= r_b >> DIGIT_W;
        r_carry <= w_carry;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_cout <= w_carry;
        end
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder (NDIGITS=4).
module tb_bcd_serial_adder;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  bcd_serial_adder #(.NDIGITS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv);
    @(negedge clk);
    a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Leaves the bench on the negedge where done is high (or after a 20-cycle bound).
  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({sum, cout, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_state: got sum=%h cout=%b busy=%b done=%b err=%b expected all 0",
               sum, cout, busy, done, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_add;
    int n, bc;
    start_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    wait_done(n, bc);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", n); end
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
    checks++;
    if (sum !== 16'h6912 || cout !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got sum=%h cout=%b err=%b busy=%b expected 6912 0 0 0",
               sum, cout, err, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got done=%b expected 0", done); end
  endtask

  task automatic test_hold;
    a = 16'h8888; b = 16'h7777; cin = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (sum !== 16'h6912 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold: got sum=%h cout=%b busy=%b done=%b expected 6912 0 0 0",
               sum, cout, busy, done);
    end
  endtask

  task automatic test_carry;
    int n, bc;
    start_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    wait_done(n, bc);
    checks++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_wrap: got sum=%h cout=%b expected 0000 1", sum, cout);
    end
    start_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    wait_done(n, bc);
    checks++;
    if (sum !== 16'h0001 || cout !== 1'b0) begin
      errors++;
      $display("FAIL carry_in: got sum=%h cout=%b expected 0001 0", sum, cout);
    end
  endtask

  task automatic test_invalid;
    int n, bc;
    start_op(16'h00A0, 16'h0000, 1'b0, 1'b0);
    wait_done(n, bc);
    checks++;
    if (n !== 4 || err !== 1'b1) begin
      errors++;
      $display("FAIL invalid_err: got n=%0d err=%b expected 4 1", n, err);
    end
    start_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_done(n, bc);
    checks++;
    if (err !== 1'b0 || sum !== 16'h0003) begin
      errors++;
      $display("FAIL invalid_clear: got err=%b sum=%h expected 0 0003", err, sum);
    end
  endtask

  task automatic test_restart_ignored;
    int pulses;
    logic [W-1:0] seen;
    pulses = 0; seen = '0;
    start_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin pulses++; seen = sum; end
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL restart_pulses: got %0d expected 1", pulses); end
    checks++;
    if (seen !== 16'h6912) begin errors++; $display("FAIL restart_sum: got %h expected 6912", seen); end
  endtask

  task automatic test_reset_mid;
    int pulses, n, bc;
    pulses = 0;
    start_op(16'h4321, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sum, cout, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_state: got sum=%h cout=%b busy=%b done=%b err=%b expected all 0",
               sum, cout, busy, done, err);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL reset_mid_nodone: got %0d active cycles expected 0", pulses); end
    start_op(16'h0005, 16'h0007, 1'b0, 1'b0);
    wait_done(n, bc);
    checks++;
    if (n !== 4 || sum !== 16'h0012 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_recover: got n=%0d sum=%h cout=%b expected 4 0012 0", n, sum, cout);
    end
  endtask

  task automatic test_sub;
    int n, bc;
    logic [W-1:0] exp1, exp2;
    logic         c1, c2;
`ifdef BCD_SUB_EN
    exp1 = 16'h0377; c1 = 1'b1;
    exp2 = 16'h9623; c2 = 1'b0;
`else
    exp1 = 16'h0623; c1 = 1'b0;
    exp2 = 16'h0623; c2 = 1'b0;
`endif
    start_op(16'h0500, 16'h0123, 1'b0, 1'b1);
    wait_done(n, bc);
    checks++;
    if (sum !== exp1 || cout !== c1) begin
      errors++;
      $display("FAIL sub_a_ge_b: got sum=%h cout=%b expected %h %b", sum, cout, exp1, c1);
    end
    start_op(16'h0123, 16'h0500, 1'b0, 1'b1);
    wait_done(n, bc);
    checks++;
    if (sum !== exp2 || cout !== c2) begin
      errors++;
      $display("FAIL sub_a_lt_b: got sum=%h cout=%b expected %h %b", sum, cout, exp2, c2);
    end
    sub = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_hold();
    test_carry();
    test_invalid();
    test_restart_ignored();
    test_reset_mid();
    test_sub();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
